// File: rtl/i2c_req_arbiter_if.sv
// Client-side request bus plus the i2c_controller launch handshake.
// The arbiter takes the slave modport; clients and the controller take the master one.
interface i2c_req_arbiter_if #(
   parameter int unsigned NREQ = 4
);
   logic [NREQ-1:0]   req;
   logic [8*NREQ-1:0] wdata;
   logic [NREQ-1:0]   gnt;
   logic [NREQ-1:0]   done;
   logic [NREQ-1:0]   err;
   logic              idle;
   logic              i2c_init;
   logic [7:0]        i2c_data;
   logic              i2c_bussy;

   modport slave (
      input  req, wdata, i2c_bussy,
      output gnt, done, err, idle, i2c_init, i2c_data
   );

   modport master (
      output req, wdata, i2c_bussy,
      input  gnt, done, err, idle, i2c_init, i2c_data
   );
endinterface

// File: rtl/i2c_req_arbiter.sv
// Round-robin arbiter sharing one i2c_controller byte engine among NREQ clients.
// Optional macro I2C_ARB_TIMEOUT_EN adds a per-wait-state abort after TIMEOUT cycles.
module i2c_req_arbiter #(
   parameter int unsigned NREQ    = 4,
   parameter int unsigned TIMEOUT = 1023,
   parameter int unsigned TW      = 10
) (
   input  logic              clk,
   input  logic              rst,
   i2c_req_arbiter_if.slave  bus
);

   localparam int unsigned PW = (NREQ > 1) ? $clog2(NREQ) : 1;

   typedef enum logic [1:0] {
      ST_IDLE   = 2'd0,
      ST_LAUNCH = 2'd1,
      ST_BUSY   = 2'd2
   } state_e;

   state_e          state_q, state_d;
   logic [PW-1:0]   ptr_q, ptr_d;
   logic [NREQ-1:0] gnt_q, gnt_d;
   logic [NREQ-1:0] done_q, done_d;
   logic            init_q, init_d;
   logic            idle_q, idle_d;
   logic [7:0]      data_q, data_d;

   logic [PW-1:0]   sel_c;
   logic            sel_found_c;
   logic [7:0]      wbyte_c;

   if ((TIMEOUT >> TW) != 0) begin : g_tw_check
      $error("TW too narrow to hold TIMEOUT");
   end

`ifdef I2C_ARB_TIMEOUT_EN
   logic [TW-1:0]   cnt_q, cnt_d;
   logic [NREQ-1:0] err_q, err_d;
   logic            tmo_c;

   assign tmo_c = (cnt_q == TW'(TIMEOUT - 1));
`endif

   // First pending request after the last grant, wrapping modulo NREQ.
   always_comb begin
      sel_found_c = 1'b0;
      sel_c       = ptr_q;
      for (int unsigned k = 1; k <= NREQ; k++) begin
         if (!sel_found_c && bus.req[PW'((32'(ptr_q) + k) % NREQ)]) begin
            sel_found_c = 1'b1;
            sel_c       = PW'((32'(ptr_q) + k) % NREQ);
         end
      end
   end

   always_comb begin
      wbyte_c = '0;
      for (int unsigned i = 0; i < NREQ; i++) begin
         if (sel_c == PW'(i)) wbyte_c = bus.wdata[8*i +: 8];
      end
   end

   // Next-state and output decode.
   always_comb begin
      state_d = state_q;
      ptr_d   = ptr_q;
      gnt_d   = gnt_q;
      done_d  = '0;
      init_d  = init_q;
      data_d  = data_q;
`ifdef I2C_ARB_TIMEOUT_EN
      err_d   = '0;
      cnt_d   = cnt_q + TW'(1);
`endif
      case (state_q)
         ST_IDLE: begin
`ifdef I2C_ARB_TIMEOUT_EN
            cnt_d = '0;
`endif
            if (sel_found_c && !bus.i2c_bussy) begin
               gnt_d   = NREQ'(1) << sel_c;
               data_d  = wbyte_c;
               init_d  = 1'b1;
               ptr_d   = sel_c;
               state_d = ST_LAUNCH;
            end
         end
         ST_LAUNCH: begin
            if (bus.i2c_bussy) begin
               init_d  = 1'b0;
               state_d = ST_BUSY;
`ifdef I2C_ARB_TIMEOUT_EN
               cnt_d   = '0;
`endif
            end
`ifdef I2C_ARB_TIMEOUT_EN
            else if (tmo_c) begin
               init_d  = 1'b0;
               gnt_d   = '0;
               err_d   = NREQ'(1) << ptr_q;
               state_d = ST_IDLE;
            end
`endif
         end
         ST_BUSY: begin
            if (!bus.i2c_bussy) begin
               gnt_d   = '0;
               done_d  = NREQ'(1) << ptr_q;
               state_d = ST_IDLE;
            end
`ifdef I2C_ARB_TIMEOUT_EN
            else if (tmo_c) begin
               gnt_d   = '0;
               err_d   = NREQ'(1) << ptr_q;
               state_d = ST_IDLE;
            end
`endif
         end
         default: begin
            state_d = ST_IDLE;
            gnt_d   = '0;
            init_d  = 1'b0;
         end
      endcase
      idle_d = (state_d == ST_IDLE);
   end

   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         state_q <= ST_IDLE;
         ptr_q   <= PW'(NREQ - 1);
         gnt_q   <= '0;
         done_q  <= '0;
         init_q  <= 1'b0;
         idle_q  <= 1'b1;
         data_q  <= '0;
      end else begin
         state_q <= state_d;
         ptr_q   <= ptr_d;
         gnt_q   <= gnt_d;
         done_q  <= done_d;
         init_q  <= init_d;
         idle_q  <= idle_d;
         data_q  <= data_d;
      end
   end

`ifdef I2C_ARB_TIMEOUT_EN
   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         cnt_q <= '0;
         err_q <= '0;
      end else begin
         cnt_q <= cnt_d;
         err_q <= err_d;
      end
   end

   assign bus.err = err_q;
`else
   assign bus.err = '0;
`endif

   assign bus.gnt      = gnt_q;
   assign bus.done     = done_q;
   assign bus.idle     = idle_q;
   assign bus.i2c_init = init_q;
   assign bus.i2c_data = data_q;

endmodule

// File: tb/tb_i2c_req_arbiter.sv
// Randomized scoreboard bench for i2c_req_arbiter with client and controller models.
module tb_i2c_req_arbiter;

   localparam int unsigned NREQ    = 4;
   localparam int unsigned TIMEOUT = 16;
   localparam int unsigned TW      = 10;
`ifdef I2C_ARB_TIMEOUT_EN
   localparam int HOLD_MAX  = 10;
   localparam int HOLD_LONG = 10;
`else
   localparam int HOLD_MAX  = 30;
   localparam int HOLD_LONG = 200;
`endif

   typedef struct packed {
      logic [7:0] idx;
      logic [7:0] data;
      logic       is_err;
   } exp_t;

   logic clk = 1'b0;
   logic rst = 1'b0;
   always #5 clk = ~clk;

   i2c_req_arbiter_if #(.NREQ(NREQ)) bus ();

   i2c_req_arbiter #(.NREQ(NREQ), .TIMEOUT(TIMEOUT), .TW(TW)) dut (
      .clk (clk),
      .rst (rst),
      .bus (bus)
   );

   int         n_checks    = 0;
   int         n_pass      = 0;
   int         outstanding = 0;
   int         cyc         = 0;
   int         model_ptr   = NREQ - 1;
   bit         ctl_en      = 1'b1;
   int         ctl_delay   = 3;
   int         ctl_hold    = 5;
   bit         chaos       = 1'b0;
   bit         tmo_mode    = 1'b0;
   exp_t       exp_q[$];
   logic [7:0] bq[NREQ][$];

   task automatic check(input bit ok, input string name, input logic [31:0] act, input logic [31:0] req);
      n_checks++;
      if (ok) n_pass++;
      else $display("FAIL %s: got 0x%0h, required 0x%0h (t=%0t)", name, act, req, $time);
   endtask

   // Reference: strict round robin over the queued bytes, each client re-requesting until empty.
   task automatic launch_round();
      int rem[NREQ];
      int taken[NREQ];
      int p;
      int total;
      bit any;
      p     = model_ptr;
      total = 0;
      for (int i = 0; i < NREQ; i++) begin
         rem[i]   = bq[i].size();
         taken[i] = 0;
      end
      do begin
         any = 1'b0;
         for (int k = 1; k <= NREQ; k++) begin
            int j;
            j = (p + k) % NREQ;
            if (rem[j] > 0) begin
               exp_q.push_back('{idx: 8'(j), data: bq[j][taken[j]], is_err: tmo_mode});
               taken[j]++;
               rem[j]--;
               total++;
               p   = j;
               any = 1'b1;
               break;
            end
         end
      end while (any);
      model_ptr = p;
      outstanding += total;
      @(negedge clk);
      for (int i = 0; i < NREQ; i++) begin
         if (bq[i].size() > 0) begin
            bus.wdata[8*i +: 8] = bq[i][0];
            bus.req[i]          = 1'b1;
         end
      end
      @(posedge clk);
      #1;
      check(bus.gnt != '0, "grant_latency", 32'(bus.gnt), 32'(1));
   endtask

   task automatic wait_drain(input string name);
      int n;
      n = 0;
      while ((outstanding != 0 || exp_q.size() != 0) && n < 5000) begin
         @(posedge clk);
         n++;
      end
      check(outstanding == 0 && exp_q.size() == 0, name, 32'(outstanding), 32'(0));
      repeat (2) @(negedge clk);
   endtask

   task automatic check_reset_outputs(input string tag);
      check(bus.gnt == '0,        {tag, "_gnt"},  32'(bus.gnt),      32'(0));
      check(bus.done == '0,       {tag, "_done"}, 32'(bus.done),     32'(0));
      check(bus.err == '0,        {tag, "_err"},  32'(bus.err),      32'(0));
      check(bus.i2c_init == 1'b0, {tag, "_init"}, 32'(bus.i2c_init), 32'(0));
      check(bus.i2c_data == 8'h0, {tag, "_data"}, 32'(bus.i2c_data), 32'(0));
      check(bus.idle == 1'b1,     {tag, "_idle"}, 32'(bus.idle),     32'(1));
   endtask

   // Controller model: raises bussy ctl_delay cycles after seeing init, holds it ctl_hold cycles.
   initial begin
      bus.i2c_bussy = 1'b0;
      forever begin
         @(negedge clk);
         if (ctl_en && rst && bus.i2c_init && !bus.i2c_bussy) begin
            repeat (ctl_delay) @(negedge clk);
            bus.i2c_bussy = 1'b1;
            repeat (ctl_hold) @(negedge clk);
            bus.i2c_bussy = 1'b0;
         end
      end
   end

   // Client models: advance to the next byte on done/err, optionally misbehave while granted.
   initial begin
      forever begin
         @(posedge clk);
         #1;
         if (rst) begin
            for (int i = 0; i < NREQ; i++) begin
               if (bus.done[i] || bus.err[i]) begin
                  if (bq[i].size() > 0) void'(bq[i].pop_front());
                  if (bq[i].size() > 0) begin
                     bus.wdata[8*i +: 8] = bq[i][0];
                     bus.req[i]          = 1'b1;
                  end else begin
                     bus.req[i] = 1'b0;
                  end
               end else if (chaos && bus.gnt[i] && $urandom_range(0, 3) == 0) begin
                  bus.req[i]          = 1'b0;
                  bus.wdata[8*i +: 8] = 8'($urandom);
               end
            end
         end
      end
   end

   // Monitor: pops the scoreboard on each grant and checks the transfer through completion.
   logic [NREQ-1:0] prev_gnt = '0;
   bit              prev_init = 1'b0;
   bit              active = 1'b0;
   bit              cur_err = 1'b0;
   int              cur_idx = 0;
   int              g_cyc = 0;
   logic [7:0]      cur_byte = '0;
   logic [NREQ-1:0] want;
   exp_t            e;

   initial begin
      forever begin
         @(posedge clk);
         #1;
         cyc++;
         if (!rst) begin
            active    = 1'b0;
            prev_gnt  = '0;
            prev_init = 1'b0;
         end else begin
            check($onehot0(bus.gnt), "gnt_onehot", 32'(bus.gnt), 32'(0));
            check($onehot0(bus.done | bus.err) && ((bus.done & bus.err) == '0),
                  "pulse_onehot", {16'(bus.done), 16'(bus.err)}, 32'(0));
`ifndef I2C_ARB_TIMEOUT_EN
            check(bus.err == '0, "err_tied", 32'(bus.err), 32'(0));
`endif
            if (prev_gnt == '0 && bus.gnt != '0) begin
               if (exp_q.size() == 0) begin
                  check(1'b0, "unexpected_grant", 32'(bus.gnt), 32'(0));
               end else begin
                  e    = exp_q.pop_front();
                  want = NREQ'(1) << e.idx;
                  check(bus.gnt == want, "grant_idx", 32'(bus.gnt), 32'(want));
                  check(bus.i2c_data == e.data, "grant_data", 32'(bus.i2c_data), 32'(e.data));
                  check(bus.i2c_init == 1'b1, "init_on_grant", 32'(bus.i2c_init), 32'(1));
                  cur_idx  = int'(e.idx);
                  cur_byte = e.data;
                  cur_err  = e.is_err;
                  active   = 1'b1;
                  g_cyc    = cyc;
               end
            end else if (active && bus.gnt != '0) begin
               check(bus.i2c_data == cur_byte, "data_stable", 32'(bus.i2c_data), 32'(cur_byte));
               if (prev_init && bus.i2c_bussy)
                  check(bus.i2c_init == 1'b0, "init_fall", 32'(bus.i2c_init), 32'(0));
               else if (prev_init && !cur_err)
                  check(bus.i2c_init == 1'b1, "init_hold", 32'(bus.i2c_init), 32'(1));
            end
            if (bus.done != '0 || bus.err != '0) begin
               if (!active) begin
                  check(1'b0, "spurious_done", {16'(bus.done), 16'(bus.err)}, 32'(0));
               end else begin
                  want = NREQ'(1) << cur_idx;
                  check({bus.done, bus.err} == (cur_err ? {NREQ'(0), want} : {want, NREQ'(0)}),
                        "completion", {16'(bus.done), 16'(bus.err)},
                        cur_err ? 32'(want) : {16'(want), 16'(0)});
                  check(bus.gnt == '0 && bus.idle && !bus.i2c_init, "release",
                        {16'(bus.gnt), 8'(bus.idle), 8'(bus.i2c_init)}, {16'(0), 8'(1), 8'(0)});
                  if (cur_err)
                     check(cyc - g_cyc == int'(TIMEOUT), "tmo_latency", 32'(cyc - g_cyc), 32'(TIMEOUT));
                  active = 1'b0;
                  outstanding--;
               end
            end
            prev_gnt  = bus.gnt;
            prev_init = bus.i2c_init;
         end
      end
   end

   initial begin
      #600000;
      $display("FAIL global_timeout: simulation did not complete, required completion");
      $fatal(1, "global timeout");
   end

   initial begin
      int n;
      bus.req   = '0;
      bus.wdata = '0;
      rst       = 1'b0;
      repeat (3) @(negedge clk);
      check_reset_outputs("por");
      rst = 1'b1;
      repeat (2) @(negedge clk);

      // All four contending: grant order 0,1,2,3,0.
      ctl_delay = 2;
      ctl_hold  = 5;
      bq[0].push_back(8'hA0);
      bq[0].push_back(8'hA0);
      bq[1].push_back(8'hA1);
      bq[2].push_back(8'hA2);
      bq[3].push_back(8'hA3);
      launch_round();
      wait_drain("drain_contention");

      ctl_delay = 3;
      ctl_hold  = HOLD_LONG;
      bq[0].push_back(8'h55);
      launch_round();
      wait_drain("drain_single");

      // Last grant to 2, then 0 and 1 together: 0 must win first.
      ctl_hold = 4;
      bq[2].push_back(8'h22);
      launch_round();
      wait_drain("drain_fair_a");
      bq[0].push_back(8'h10);
      bq[1].push_back(8'h11);
      launch_round();
      wait_drain("drain_fair_b");

      chaos = 1'b1;
      for (int r = 0; r < 24; r++) begin
         ctl_delay = int'($urandom_range(1, 4));
         ctl_hold  = int'($urandom_range(1, HOLD_MAX));
         for (int i = 0; i < NREQ; i++) begin
            if ($urandom_range(0, 1) == 1) begin
               int c;
               c = int'($urandom_range(1, 3));
               for (int b = 0; b < c; b++) bq[i].push_back(8'($urandom));
            end
         end
         n = 0;
         for (int i = 0; i < NREQ; i++) n += bq[i].size();
         if (n == 0) bq[$urandom_range(0, NREQ - 1)].push_back(8'($urandom));
         launch_round();
         wait_drain("drain_random");
      end
      chaos = 1'b0;

      // Reset while the controller is busy.
      ctl_delay = 1;
      ctl_hold  = 40;
      bq[1].push_back(8'h3C);
      launch_round();
      n = 0;
      while (!bus.i2c_bussy && n < 100) begin
         @(negedge clk);
         n++;
      end
      check(bus.i2c_bussy == 1'b1, "rst_wait_bussy", 32'(bus.i2c_bussy), 32'(1));
      repeat (3) @(negedge clk);
      #2;
      rst = 1'b0;
      #1;
      check_reset_outputs("midrst");
      for (int i = 0; i < NREQ; i++) bq[i].delete();
      bus.req = '0;
      exp_q.delete();
      outstanding = 0;
      model_ptr   = NREQ - 1;
      n = 0;
      while (bus.i2c_bussy && n < 200) begin
         @(negedge clk);
         n++;
      end
      @(negedge clk);
      rst = 1'b1;
      ctl_hold = 4;
      bq[2].push_back(8'h77);
      launch_round();
      wait_drain("drain_after_rst");

`ifdef I2C_ARB_TIMEOUT_EN
      // Controller never answers: expect an abort TIMEOUT cycles after launch.
      ctl_en   = 1'b0;
      tmo_mode = 1'b1;
      bq[0].push_back(8'h99);
      launch_round();
      wait_drain("drain_timeout");
      tmo_mode = 1'b0;
      ctl_en   = 1'b1;
`endif

      repeat (4) @(negedge clk);
      $display("%0d/%0d checks passed", n_pass, n_checks);
      $finish;
   end

endmodule
